// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the CoreUART transmit arbiter: FSM state encoding
// and the largest supported requester count.
package uart_tx_arb_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ACCEPT    = 3'd1,
        ST_LOAD      = 3'd2,
        ST_WAIT_DROP = 3'd3,
        ST_WAIT_RDY  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/uart_tx_rr_pick.sv
// Combinational round-robin picker. The search starts at the channel just
// after the pointer and wraps, so the channel named by the pointer has the
// lowest priority. Returns the winner as one-hot and as an index.
module uart_tx_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int IDXW   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible_i,
    input  logic [IDXW-1:0]   ptr_i,
    output logic [NUM_CH-1:0] winner_o,
    output logic [IDXW-1:0]   idx_o
);

    logic found;
    int   cand;

    // Walk the channels in priority order and keep the first eligible one
    always_comb begin
        winner_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = (int'(ptr_i) + k) % NUM_CH;
            if (!found && eligible_i[cand]) begin
                found          = 1'b1;
                winner_o[cand] = 1'b1;
                idx_o          = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one CoreUART transmitter (non-FIFO build) among NUM_CH byte
// requesters. Round-robin arbitration with an optional packet lock; each
// accepted byte is written to the holding register, strobed into the
// transmitter, and the next grant waits for txrdy to fall and rise again.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter bit LOCK_EN = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [NUM_CH-1:0]     req_valid_i,
    input  logic [8*NUM_CH-1:0]   req_data_i,
    input  logic [NUM_CH-1:0]     req_last_i,
    input  logic [NUM_CH-1:0]     ch_enable_i,
    output logic [NUM_CH-1:0]     req_ready_o,
    input  logic                  txrdy_i,
    output logic [7:0]            tx_hold_reg_o,
    output logic                  tx_load_o,
    output logic [NUM_CH-1:0]     grant_o,
    output logic                  busy_o
);

    localparam int IDXW = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : gBadNumCh
        $error("uart_tx_arbiter: NUM_CH must be within 2..MAX_CH");
    end

    arb_state_e        state_q, state_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic [IDXW-1:0]   grantIdx_q, grantIdx_d;
    logic [IDXW-1:0]   lockCh_q, lockCh_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [7:0]        holdReg_q, holdReg_d;
    logic              lock_q, lock_d;

    logic [NUM_CH-1:0] lockMask;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] pickWinner;
    logic [IDXW-1:0]   pickIdx;
    logic              lockRelease;
    logic [7:0]        selData;
    logic              selLast;

    // Mux out the granted channel's byte and last flag, and decode the lock channel
    always_comb begin
        selData  = '0;
        selLast  = 1'b0;
        lockMask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grantIdx_q == IDXW'(i)) begin
                selData = req_data_i[8*i +: 8];
                selLast = req_last_i[i];
            end
            lockMask[i] = (lockCh_q == IDXW'(i));
        end
    end

    // A lock on a channel that has been disabled is dropped, and that same
    // IDLE cycle arbitrates over the unmasked set so nobody stalls.
    assign lockRelease = lock_q && ((lockMask & ch_enable_i) == '0);
    assign eligible    = req_valid_i & ch_enable_i &
                         ((lock_q && !lockRelease) ? lockMask : {NUM_CH{1'b1}});

    uart_tx_rr_pick #(
        .NUM_CH (NUM_CH),
        .IDXW   (IDXW)
    ) uPick (
        .eligible_i (eligible),
        .ptr_i      (ptr_q),
        .winner_o   (pickWinner),
        .idx_o      (pickIdx)
    );

    // Next-state and strobe decode for the grant/load/handshake sequence
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        grantIdx_d  = grantIdx_q;
        holdReg_d   = holdReg_q;
        lock_d      = lock_q;
        lockCh_d    = lockCh_q;
        req_ready_o = '0;
        tx_load_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lockRelease) begin
                    lock_d = 1'b0;
                end
                if (txrdy_i && (eligible != '0)) begin
                    grant_d    = pickWinner;
                    grantIdx_d = pickIdx;
                    ptr_d      = pickIdx;
                    state_d    = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                req_ready_o = grant_q;
                holdReg_d   = selData;
                if (LOCK_EN) begin
                    lock_d   = ~selLast;
                    lockCh_d = grantIdx_q;
                end
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tx_load_o = 1'b1;
                state_d   = ST_WAIT_DROP;
            end
            ST_WAIT_DROP: begin
                if (!txrdy_i) begin
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (txrdy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, grant, holding register and lock registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= IDXW'(NUM_CH - 1);
            grant_q    <= '0;
            grantIdx_q <= '0;
            holdReg_q  <= 8'h00;
            lock_q     <= 1'b0;
            lockCh_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            grantIdx_q <= grantIdx_d;
            holdReg_q  <= holdReg_d;
            lock_q     <= lock_d;
            lockCh_q   <= lockCh_d;
        end
    end

    assign tx_hold_reg_o = holdReg_q;
    assign grant_o       = grant_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-channel byte sources, a transmitter model
// that drops txrdy after each load, and a scoreboard of expected accepts.
module tb_uart_tx_arbiter;

    localparam int NCH      = 4;
    localparam int DROP_LEN = 20;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             resetN;
    logic [NCH-1:0]   reqValid = '0;
    logic [8*NCH-1:0] reqData  = '0;
    logic [NCH-1:0]   reqLast  = '0;
    logic [NCH-1:0]   chEnable;
    logic [NCH-1:0]   reqReady;
    logic             txrdy;
    logic [7:0]       txHoldReg;
    logic             txLoad;
    logic [NCH-1:0]   grant;
    logic             busy;

    int   assertCount = 0;
    int   failCount   = 0;
    exp_t expQ[$];

    logic [7:0] srcData    [NCH][32];
    logic       srcLastArr [NCH][32];
    int         srcWr      [NCH];
    int         srcRd      [NCH];
    bit         consumed   [NCH];

    logic       pendLoad = 1'b0;
    logic [7:0] pendData = 8'h00;
    int         readyCount = 0;
    int         loadCount  = 0;
    int         riseCount  = 0;
    logic       modelOn    = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_CH  (NCH),
        .LOCK_EN (1'b1)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (resetN),
        .req_valid_i   (reqValid),
        .req_data_i    (reqData),
        .req_last_i    (reqLast),
        .ch_enable_i   (chEnable),
        .req_ready_o   (reqReady),
        .txrdy_i       (txrdy),
        .tx_hold_reg_o (txHoldReg),
        .tx_load_o     (txLoad),
        .grant_o       (grant),
        .busy_o        (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [7:0] data, input logic last);
        srcData[ch][srcWr[ch]]    = data;
        srcLastArr[ch][srcWr[ch]] = last;
        srcWr[ch]++;
    endtask

    task automatic expectAccept(input int ch, input logic [7:0] data);
        exp_t e;
        e.ch   = ch[1:0];
        e.data = data;
        expQ.push_back(e);
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (!(expQ.size() == 0 && !pendLoad && busy === 1'b0 && txrdy === 1'b1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "Done"}, (expQ.size() == 0 && !pendLoad && busy === 1'b0) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic resetDut();
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    // Byte sources: present the head of each channel's list, advance after an accept
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NCH; c++) begin
                if (consumed[c]) begin
                    srcRd[c]++;
                    consumed[c] = 1'b0;
                end
                if (srcRd[c] < srcWr[c]) begin
                    reqValid[c]        = 1'b1;
                    reqData[8*c +: 8]  = srcData[c][srcRd[c]];
                    reqLast[c]         = srcLastArr[c][srcRd[c]];
                end else begin
                    reqValid[c] = 1'b0;
                    reqLast[c]  = 1'b0;
                end
            end
        end
    end

    // Transmitter model: after a load, txrdy drops for DROP_LEN clocks
    initial begin
        forever begin
            @(negedge clk);
            if (modelOn && txLoad === 1'b1) begin
                @(posedge clk);
                #1 txrdy = 1'b0;
                repeat (DROP_LEN) @(posedge clk);
                #1 txrdy = 1'b1;
                riseCount++;
            end
        end
    end

    // Scoreboard monitor: every accept must match the head of the queue and
    // be followed next cycle by a load of that byte
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (pendLoad) begin
                checkOutput("txLoad", 32'(txLoad), 32'd1);
                checkOutput("txHoldReg", 32'(txHoldReg), 32'(pendData));
                pendLoad = 1'b0;
            end else if (txLoad !== 1'b0) begin
                checkOutput("spuriousLoad", 32'(txLoad), 32'd0);
            end
            if (txLoad === 1'b1) loadCount++;
            if (reqReady !== '0) begin
                readyCount++;
                for (int c = 0; c < NCH; c++) begin
                    if (reqReady[c] === 1'b1) consumed[c] = 1'b1;
                end
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedAccept", 32'(reqReady), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("acceptCh", 32'(reqReady), 32'd1 << e.ch);
                    checkOutput("grant", 32'(grant), 32'd1 << e.ch);
                    pendData = e.data;
                    pendLoad = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int rc;
        int lc;
        int rb;
        int lb;

        resetN   = 1'b1;
        chEnable = '1;
        txrdy    = 1'b1;
        modelOn  = 1'b1;
        #2 resetN = 1'b0;
        #1;
        checkOutput("rstGrant", 32'(grant), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstHold", 32'(txHoldReg), 32'd0);
        checkOutput("rstLoad", 32'(txLoad), 32'd0);
        checkOutput("rstReady", 32'(reqReady), 32'd0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        // Single byte on channel 2: cycle-exact handshake and busy window
        applyStimulus(2, 8'hA5, 1'b1);
        expectAccept(2, 8'hA5);
        n = 0;
        while (reqReady === '0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t1Ready", 32'(reqReady), 32'b0100);
        checkOutput("t1Latency", 32'(n), 32'd2);
        @(negedge clk);
        checkOutput("t1Load", 32'(txLoad), 32'd1);
        checkOutput("t1Hold", 32'(txHoldReg), 32'hA5);
        checkOutput("t1Grant", 32'(grant), 32'b0100);
        @(negedge clk);
        checkOutput("t1TxrdyLow", 32'(txrdy), 32'd0);
        checkOutput("t1BusyLow", 32'(busy), 32'd1);
        n = 0;
        while (txrdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t1BusyAtRise", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("t1BusyIdle", 32'(busy), 32'd0);
        waitDone("t1");

        // All four channels streaming, one byte per packet: strict rotation
        resetDut();
        rb = riseCount;
        lb = loadCount;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < NCH; c++) begin
                applyStimulus(c, 8'(16 * c + k + 1), 1'b1);
                expectAccept(c, 8'(16 * c + k + 1));
            end
        end
        waitDone("t2");
        checkOutput("t2LoadPerRise", 32'(loadCount - lb), 32'(riseCount - rb));
        checkOutput("t2Loads", 32'(loadCount - lb), 32'd12);

        // Packet lock: three channel-1 bytes hold off a waiting channel 0
        applyStimulus(0, 8'h30, 1'b1);
        expectAccept(0, 8'h30);
        waitDone("t3a");
        applyStimulus(1, 8'h31, 1'b0);
        applyStimulus(1, 8'h32, 1'b0);
        applyStimulus(1, 8'h33, 1'b1);
        applyStimulus(0, 8'h34, 1'b1);
        expectAccept(1, 8'h31);
        expectAccept(1, 8'h32);
        expectAccept(1, 8'h33);
        expectAccept(0, 8'h34);
        waitDone("t3");

        // Lock on channel 3, then release it by disabling channel 3
        applyStimulus(3, 8'h40, 1'b0);
        expectAccept(3, 8'h40);
        waitDone("t4a");
        rc = readyCount;
        applyStimulus(0, 8'h41, 1'b1);
        expectAccept(0, 8'h41);
        repeat (6) @(negedge clk);
        checkOutput("t4LockMask", 32'(readyCount - rc), 32'd0);
        @(posedge clk);
        #1 chEnable[3] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t4SameCycle", 32'(reqReady), 32'b0001);
        waitDone("t4");
        chEnable[3] = 1'b1;

        // txrdy low across reset release: nothing may start until it rises
        modelOn = 1'b0;
        txrdy   = 1'b0;
        resetN  = 1'b0;
        applyStimulus(0, 8'h5A, 1'b1);
        expectAccept(0, 8'h5A);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        rc = readyCount;
        lc = loadCount;
        repeat (10) @(negedge clk);
        checkOutput("t5NoReady", 32'(readyCount - rc), 32'd0);
        checkOutput("t5NoLoad", 32'(loadCount - lc), 32'd0);
        checkOutput("t5Idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        modelOn = 1'b1;
        txrdy   = 1'b1;
        waitDone("t5");
        checkOutput("t5Grant", 32'(grant), 32'b0001);

        // Reset in WAIT_RDY: outputs clear at once, pointer restarts at channel 0
        applyStimulus(1, 8'h66, 1'b1);
        expectAccept(1, 8'h66);
        n = 0;
        while (txrdy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6Drop", 32'(txrdy), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("t6BusyBefore", 32'(busy), 32'd1);
        @(posedge clk);
        #3 resetN = 1'b0;
        #1;
        checkOutput("t6Busy", 32'(busy), 32'd0);
        checkOutput("t6Grant", 32'(grant), 32'd0);
        checkOutput("t6Hold", 32'(txHoldReg), 32'd0);
        checkOutput("t6Load", 32'(txLoad), 32'd0);
        checkOutput("t6Ready", 32'(reqReady), 32'd0);
        applyStimulus(2, 8'h72, 1'b1);
        applyStimulus(0, 8'h70, 1'b1);
        expectAccept(0, 8'h70);
        expectAccept(2, 8'h72);
        n = 0;
        while (txrdy !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        resetN = 1'b1;
        waitDone("t6");
        checkOutput("t6FinalGrant", 32'(grant), 32'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
